// File: rtl/hex_record_writer_pkg.sv
// Shared constants and state encoding for the Intel HEX record writer.
package hex_record_writer_pkg;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam logic [7:0] REC_DATA    = 8'h00;
    localparam logic [7:0] REC_EOF     = 8'h01;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_COLON   = 5'd1,
        S_LEN_H   = 5'd2,
        S_LEN_L   = 5'd3,
        S_ADR3    = 5'd4,
        S_ADR2    = 5'd5,
        S_ADR1    = 5'd6,
        S_ADR0    = 5'd7,
        S_TYP_H   = 5'd8,
        S_TYP_L   = 5'd9,
        S_FETCH   = 5'd10,
        S_WAIT_RD = 5'd11,
        S_DAT_H   = 5'd12,
        S_DAT_L   = 5'd13,
        S_CK_H    = 5'd14,
        S_CK_L    = 5'd15,
        S_CR      = 5'd16,
        S_LF      = 5'd17,
        S_DONE    = 5'd18
    } state_e;

    // True for states that present a character on the output stream.
    function automatic logic is_emit_state(input state_e s);
        logic r;
        case (s)
            S_IDLE, S_FETCH, S_WAIT_RD, S_DONE: r = 1'b0;
            default:                            r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_record_writer_nibble.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_to_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits 0-9 map from '0', digits A-F map from 'A' - 10.
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/hex_record_writer.sv
// Intel HEX encoder: streams a memory byte range as data records plus EOF.
// All outputs are registered; the character for the next state is computed
// from next-state values so out_data lines up with the state presenting it.
module hex_record_writer
    import hex_record_writer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 15,
    parameter int BYTES_PER_LINE = 16,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [7:0]            mem_rd_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready
);

    localparam logic [LEN_WIDTH-1:0] BPL_L = LEN_WIDTH'(BYTES_PER_LINE);
    localparam logic [7:0]           BPL_B = 8'(BYTES_PER_LINE);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    total_q, total_d;
    logic [7:0]              line_q, line_d;
    logic [15:0]             line_addr_q, line_addr_d;
    logic [7:0]              byte_q, byte_d;
    logic [7:0]              sum_q, sum_d;
    logic                    is_eof_q, is_eof_d;
    logic                    busy_q, done_q, rd_en_q, out_valid_q;
    logic [7:0]              out_data_q;

    logic                    hs_s;
    logic [7:0]              ll_s;
    logic [15:0]             la_s;
    logic [7:0]              ck_s;
    logic [3:0]              nib_s;
    logic [7:0]              nib_ascii_s;
    logic [7:0]              char_s;

    assign hs_s = out_valid_q & out_ready;
    assign ll_s = (total_q < BPL_L) ? 8'(total_q) : BPL_B;
    assign la_s = 16'(addr_q);
    assign ck_s = 8'h00 - sum_d;

    hex_nibble_to_ascii u_nib (
        .nibble_i (nib_s),
        .ascii_o  (nib_ascii_s)
    );

    // State and datapath registers, plus the registered output stage.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            total_q     <= '0;
            line_q      <= 8'h00;
            line_addr_q <= 16'h0000;
            byte_q      <= 8'h00;
            sum_q       <= 8'h00;
            is_eof_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            line_q      <= line_d;
            line_addr_q <= line_addr_d;
            byte_q      <= byte_d;
            sum_q       <= sum_d;
            is_eof_q    <= is_eof_d;
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            rd_en_q     <= (state_d == S_FETCH);
            out_valid_q <= is_emit_state(state_d);
            out_data_q  <= char_s;
        end
    end

    // Next-state logic: emit states advance only on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLON; else state_d = S_IDLE;
            S_COLON:   if (hs_s) state_d = S_LEN_H; else state_d = S_COLON;
            S_LEN_H:   if (hs_s) state_d = S_LEN_L; else state_d = S_LEN_H;
            S_LEN_L:   if (hs_s) state_d = S_ADR3; else state_d = S_LEN_L;
            S_ADR3:    if (hs_s) state_d = S_ADR2; else state_d = S_ADR3;
            S_ADR2:    if (hs_s) state_d = S_ADR1; else state_d = S_ADR2;
            S_ADR1:    if (hs_s) state_d = S_ADR0; else state_d = S_ADR1;
            S_ADR0:    if (hs_s) state_d = S_TYP_H; else state_d = S_ADR0;
            S_TYP_H:   if (hs_s) state_d = S_TYP_L; else state_d = S_TYP_H;
            S_TYP_L: begin
                if (hs_s) begin
                    state_d = (line_q == 8'h00) ? S_CK_H : S_FETCH;
                end else begin
                    state_d = S_TYP_L;
                end
            end
            S_FETCH:   state_d = S_WAIT_RD;
            S_WAIT_RD: state_d = S_DAT_H;
            S_DAT_H:   if (hs_s) state_d = S_DAT_L; else state_d = S_DAT_H;
            S_DAT_L: begin
                if (hs_s) begin
                    state_d = (line_q == 8'h01) ? S_CK_H : S_FETCH;
                end else begin
                    state_d = S_DAT_L;
                end
            end
            S_CK_H:    if (hs_s) state_d = S_CK_L; else state_d = S_CK_H;
            S_CK_L:    if (hs_s) state_d = S_CR; else state_d = S_CK_L;
            S_CR:      if (hs_s) state_d = S_LF; else state_d = S_CR;
            S_LF: begin
                if (hs_s) begin
                    if ((total_q != '0) || !is_eof_q) begin
                        state_d = S_COLON;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_LF;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the job, set up each record header, accumulate checksum.
    always_comb begin
        addr_d      = addr_q;
        total_d     = total_q;
        line_d      = line_q;
        line_addr_d = line_addr_q;
        byte_d      = byte_q;
        sum_d       = sum_q;
        is_eof_d    = is_eof_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    total_d  = length;
                    is_eof_d = (length == {LEN_WIDTH{1'b0}});
                end else begin
                    addr_d   = addr_q;
                end
            end
            S_COLON: begin
                if (hs_s && is_eof_q) begin
                    line_d      = 8'h00;
                    line_addr_d = 16'h0000;
                    sum_d       = REC_EOF;
                end else if (hs_s) begin
                    line_d      = ll_s;
                    line_addr_d = la_s;
                    sum_d       = ll_s + la_s[15:8] + la_s[7:0] + REC_DATA;
                end else begin
                    sum_d       = sum_q;
                end
            end
            S_WAIT_RD: begin
                byte_d = mem_rd_data;
                sum_d  = sum_q + mem_rd_data;
            end
            S_DAT_L: begin
                if (hs_s) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    line_d  = line_q - 8'h01;
                    total_d = total_q - LEN_WIDTH'(1);
                end else begin
                    addr_d  = addr_q;
                end
            end
            S_LF: begin
                if (hs_s && (total_q == '0) && !is_eof_q) begin
                    is_eof_d = 1'b1;
                end else begin
                    is_eof_d = is_eof_q;
                end
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    // Output decode: character the next state will present.
    always_comb begin
        nib_s  = 4'h0;
        char_s = 8'h00;
        case (state_d)
            S_LEN_H: nib_s = line_d[7:4];
            S_LEN_L: nib_s = line_d[3:0];
            S_ADR3:  nib_s = line_addr_d[15:12];
            S_ADR2:  nib_s = line_addr_d[11:8];
            S_ADR1:  nib_s = line_addr_d[7:4];
            S_ADR0:  nib_s = line_addr_d[3:0];
            S_DAT_H: nib_s = byte_d[7:4];
            S_DAT_L: nib_s = byte_d[3:0];
            S_CK_H:  nib_s = ck_s[7:4];
            S_CK_L:  nib_s = ck_s[3:0];
            default: nib_s = 4'h0;
        endcase
        case (state_d)
            S_COLON: char_s = ASCII_COLON;
            S_TYP_H: char_s = ASCII_ZERO;
            S_TYP_L: char_s = ASCII_ZERO + {7'h00, is_eof_d};
            S_CR:    char_s = ASCII_CR;
            S_LF:    char_s = ASCII_LF;
            S_LEN_H, S_LEN_L, S_ADR3, S_ADR2, S_ADR1, S_ADR0,
            S_DAT_H, S_DAT_L, S_CK_H, S_CK_L: char_s = nib_ascii_s;
            default: char_s = 8'h00;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_hex_record_writer.sv
// Scoreboard bench for hex_record_writer: expected characters and read
// addresses are queued at stimulus time and popped as the DUT produces them.
module tb_hex_record_writer;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic        start;
    logic [14:0] base_addr;
    logic [15:0] length;
    logic        busy, done, mem_rd_en, out_valid;
    logic [14:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  out_data;
    logic        out_ready;

    logic [7:0]  mem [0:32767];
    logic [7:0]  exp_q [$];
    logic [14:0] rd_q  [$];
    int checks = 0;
    int errors = 0;

    always #5 clk_74a = ~clk_74a;

    // Synchronous memory model with one-cycle read latency.
    always @(posedge clk_74a) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    hex_record_writer dut (
        .clk_74a     (clk_74a),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    task automatic push_rec(input string body);
        for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic start_xfer(input logic [14:0] b, input logic [15:0] l);
        @(negedge clk_74a);
        base_addr = b; length = l; start = 1'b1; out_ready = 1'b0;
        @(negedge clk_74a);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
    endtask

    // Drive out_ready and check the stream until done or the budget runs out.
    task automatic run_stream(input int budget, input bit rnd, input bit poke);
        int cyc = 0;
        int done_cnt = 0;
        int low_run = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        logic [14:0] ea;
        while (cyc < budget && done_cnt == 0) begin
            @(negedge clk_74a);
            if (!rnd) begin
                out_ready = 1'b1;
            end else if (low_run > 0) begin
                out_ready = 1'b0; low_run--;
            end else if ($urandom_range(0, 7) == 0) begin
                out_ready = 1'b0; low_run = 4;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (poke && cyc == 10) begin
                start = 1'b1; base_addr = 15'h7FFF; length = 16'd2;
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_char: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL char: got %h want %h", out_data, e);
                    end
                end
            end
            if (mem_rd_en) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read: got addr %h want none", mem_rd_addr);
                end else begin
                    ea = rd_q.pop_front();
                    if (mem_rd_addr !== ea) begin
                        errors++;
                        $display("FAIL rd_addr: got %h want %h", mem_rd_addr, ea);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) done_cnt++;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_timeout: got %0d done pulses want 1", done_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d chars %0d reads pending want 0 0", exp_q.size(), rd_q.size());
        end
        exp_q.delete();
        rd_q.delete();
        @(negedge clk_74a);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_74a);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || mem_rd_en !== 1'b0 ||
            out_data !== 8'h00 || mem_rd_addr !== 15'h0000) begin
            errors++;
            $display("FAIL reset_state: got b=%b d=%b v=%b r=%b od=%h a=%h want all 0",
                     busy, done, out_valid, mem_rd_en, out_data, mem_rd_addr);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_74a);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic setup_basic();
        mem[15'h0100] = 8'h0C; mem[15'h0101] = 8'h94; mem[15'h0102] = 8'h5C;
        push_rec(":030100000C945C00");
        push_rec(":00000001FF");
        rd_q.push_back(15'h0100); rd_q.push_back(15'h0101); rd_q.push_back(15'h0102);
    endtask

    task automatic test_basic();
        setup_basic();
        start_xfer(15'h0100, 16'd3);
        run_stream(500, 1'b0, 1'b0);
    endtask

    task automatic test_line_split();
        for (int i = 0; i < 17; i++) begin
            mem[i] = 8'hFF;
            rd_q.push_back(15'(i));
        end
        push_rec(":10000000FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00");
        push_rec(":01001000FFF0");
        push_rec(":00000001FF");
        start_xfer(15'h0000, 16'd17);
        run_stream(1000, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        push_rec(":00000001FF");
        start_xfer(15'h0040, 16'd0);
        run_stream(200, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        setup_basic();
        start_xfer(15'h0100, 16'd3);
        run_stream(3000, 1'b1, 1'b0);
    endtask

    task automatic setup_wrap();
        mem[15'h7FFF] = 8'h12; mem[15'h0000] = 8'h34;
        push_rec(":027FFF0012343A");
        push_rec(":00000001FF");
        rd_q.push_back(15'h7FFF); rd_q.push_back(15'h0000);
    endtask

    task automatic test_addr_wrap();
        setup_wrap();
        start_xfer(15'h7FFF, 16'd2);
        run_stream(500, 1'b0, 1'b0);
    endtask

    task automatic test_reset_restart();
        int hs_cnt = 0;
        int cyc = 0;
        bit hit = 1'b0;
        mem[15'h0100] = 8'h0C; mem[15'h0101] = 8'h94; mem[15'h0102] = 8'h5C;
        start_xfer(15'h0100, 16'd3);
        // After 10 accepted characters the DUT is presenting DAT_L of byte 0.
        while (cyc < 200 && !hit) begin
            @(negedge clk_74a);
            if (hs_cnt == 10 && out_valid) begin
                out_ready = 1'b0;
                hit = 1'b1;
            end else begin
                out_ready = 1'b1;
                if (out_valid) hs_cnt++;
            end
            cyc++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_dat_l: got %0d chars want 10", hs_cnt);
        end
        checks++;
        if (out_data !== 8'h43) begin
            errors++;
            $display("FAIL dat_l_char: got %h want 43", out_data);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b b=%b r=%b want 0 0 0", out_valid, busy, mem_rd_en);
        end
        @(negedge clk_74a);
        reset_n = 1'b1;
        @(negedge clk_74a);
        // Restart; a second start pulsed mid-transfer must be ignored.
        setup_basic();
        start_xfer(15'h0100, 16'd3);
        run_stream(500, 1'b0, 1'b1);
        // A start from IDLE is accepted again.
        setup_wrap();
        start_xfer(15'h7FFF, 16'd2);
        run_stream(500, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = 15'h0000; length = 16'h0000;
        out_ready = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk_74a);
        test_reset();
        test_basic();
        test_line_split();
        test_empty();
        test_backpressure();
        test_addr_wrap();
        test_reset_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_record_writer.md
Name: hex_record_writer

Overview:
- Intel HEX encoder. Reads a byte range from the core's 15-bit-addressed memory (ROM/EEPROM image) and emits it as an ASCII Intel HEX text stream: data records, then an EOF record.
- Inverse of the bridge-side hex loader. Used to dump EEPROM/save data back to the APF bridge in the same text format the loader consumes.
- Output is a byte stream with a valid/ready handshake. Memory reads are synchronous with 1-cycle latency.

Parameters:
- ADDR_WIDTH, 15, memory address width. Must be ≤16; zero-extended into the 16-bit record address field.
- BYTES_PER_LINE, 16, maximum data bytes per record, range 1–255.
- LEN_WIDTH, 16, width of the transfer length input.

Ports:
- clk_74a  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first memory address; latched on start.
- length  in  LEN_WIDTH  byte count; latched on start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final LF of the EOF record is accepted.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  out_data holds a character.
- out_data  out  8  ASCII character.
- out_ready  in  1  sink accepts when out_valid && out_ready.

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, out_valid, mem_rd_en all 0; out_data 0; mem_rd_addr 0; checksum 0.
- Record format: ':' LL AAAA TT DD..DD CC CR(0x0D) LF(0x0A).
  - All hex digits uppercase: nibble 0–9 → 0x30+n, A–F → 0x37+n.
  - TT is 00 for data records and 01 for the EOF record.
  - EOF record is exactly ":00000001FF\r\n".
- Line splitting: LL = min(remaining, BYTES_PER_LINE). AAAA = 16-bit zero-extended memory address of the line's first byte.
- Checksum: 8-bit two's complement of the mod-256 sum of LL, AAAA[15:8], AAAA[7:0], TT and every data byte. Accumulated on the fly.
- States: IDLE, COLON, LEN_H, LEN_L, ADR3, ADR2, ADR1, ADR0, TYP_H, TYP_L, FETCH, WAIT_RD, DAT_H, DAT_L, CK_H, CK_L, CR, LF, DONE.
  - The EOF record reuses the same header, checksum and line-ending states, with an is_eof flag set, LL=0 and TT=01.
- Character emit states:
  - A state presents its character with out_valid=1.
  - It advances only on the handshake cycle (out_valid && out_ready).
  - out_data must stay stable while stalled.
  - out_valid never drops without a handshake, except on reset.
- Data fetch:
  - FETCH asserts mem_rd_en for exactly one cycle with the current address.
  - WAIT_RD captures mem_rd_data into a byte register and adds it to the checksum.
  - DAT_H emits the high nibble, then DAT_L emits the low nibble.
  - After DAT_L: increment the address (wraps mod 2^ADDR_WIDTH) and decrement the line and total counters. If line bytes remain, go to FETCH; otherwise go to CK_H.
- Line transitions after LF:
  - If total bytes remain, start a new data record at COLON.
  - Else if !is_eof, set is_eof and go to COLON.
  - Else go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- length=0: emits only the EOF record.
- start while busy is ignored. base_addr and length changing mid-transfer have no effect.
- Address wrap inside a line is allowed. The record address field keeps the line's first address; the loader side is responsible for interpretation.
- Reset mid-transfer aborts immediately. No partial-record completion is guaranteed.
- Throughput: 2 characters per data byte; max 1 character/cycle when out_ready is held high.

Decomposition:
- Shared package holds the ASCII constants (COLON 0x3A, CR 0x0D, LF 0x0A), the record type constants (DATA 0x00, EOF 0x01), and the state enum.
- One natural sub-module, hex_nibble_to_ascii: combinational 4-bit to uppercase ASCII. It is shared with the loader's inverse decode tests.

Test Plan:
- Basic record: mem[0x0100..0x0102] = 0C 94 5C; start base=0x0100, length=3; out_ready=1 → exact stream ":030100000C945C00\r\n:00000001FF\r\n", then done for one cycle, busy=0.
- Line split: mem all 0xFF; base=0x0000, length=17 → three records:
  - ":10000000" + 16×"FF" + "00\r\n"
  - ":01001000FF" + "F0\r\n"
  - the EOF record.
- Empty transfer: length=0 → only ":00000001FF\r\n"; mem_rd_en never asserted.
- Backpressure: basic-record case with random out_ready (including 5-cycle low stretches) → out_data stable during each stall; the identical 32-character sequence is delivered with no loss or duplication.
- Address wrap: mem[0x7FFF]=0x12, mem[0x0000]=0x34; base=0x7FFF, length=2 → ":027FFF0012343A\r\n" + EOF; reads issued at 0x7FFF then 0x0000.
- Reset and restart:
  - Assert reset_n low during the DAT_L of the first record → out_valid, busy and mem_rd_en go to 0 asynchronously.
  - After release, start is ignored if asserted while busy and accepted from IDLE.
  - A fresh start reproduces the full correct stream.
